// File: rtl/mult_top_if.sv
// Streaming operand/result bundle for the binary32 multiplier.
// The master drives operand pairs and the slave returns products.
interface mult_top_if;
  logic        valid_in;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        valid_out;
  logic [31:0] out0;

  modport master (output valid_in, in0, in1, input  valid_out, out0);
  modport slave  (input  valid_in, in0, in1, output valid_out, out0);
endinterface

// File: rtl/mult_top.sv
// Pipelined binary32 multiplier: RNE rounding, flush-to-zero for denormals,
// canonical NaN output, fixed latency and no back-pressure.
module mult_top (
  input  logic      clk,
  input  logic      reset,
  mult_top_if.slave bus
);
  localparam int STAGES = 4;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

  typedef struct packed {
    logic        sign;
    kind_e       kind;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
  } s1_t;

  typedef struct packed {
    logic              sign;
    kind_e             kind;
    logic signed [9:0] exp;
    logic [47:0]       prod;
  } s2_t;

  // vld_pipe[0] tags the captured operands; vld_pipe[STAGES] is valid_out.
  logic [STAGES:0] vld_pipe;
  logic [31:0]     a_q, b_q;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [31:0]     s3_d, s3_q;
  logic [31:0]     out_q;

  // S1: unpack and classify
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    fa     = a_q[22:0];
    fb     = b_q[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);

    s1_d.sign = a_q[31] ^ b_q[31];
    s1_d.ea   = ea;
    s1_d.eb   = eb;
    s1_d.ma   = {1'b1, fa};
    s1_d.mb   = {1'b1, fb};
    if (a_nan || b_nan)                         s1_d.kind = K_NAN;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) s1_d.kind = K_NAN;
    else if (a_inf || b_inf)                    s1_d.kind = K_INF;
    else if (a_zero || b_zero)                  s1_d.kind = K_ZERO;
    else                                        s1_d.kind = K_NORM;
  end

  // S2: mantissa product and biased exponent sum
  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.kind = s1_q.kind;
    s2_d.prod = s1_q.ma * s1_q.mb;
    s2_d.exp  = $signed({2'b00, s1_q.ea}) + $signed({2'b00, s1_q.eb}) - 10'sd127;
  end

  // S3: normalize, round to nearest even, overflow/underflow and specials
  logic [22:0]       frac;
  logic              guard, sticky, rnd;
  logic [24:0]       mant_r;
  logic signed [9:0] e_n;

  always_comb begin
    if (s2_q.prod[47]) begin
      frac   = s2_q.prod[46:24];
      guard  = s2_q.prod[23];
      sticky = |s2_q.prod[22:0];
      e_n    = s2_q.exp + 10'sd1;
    end else begin
      frac   = s2_q.prod[45:23];
      guard  = s2_q.prod[22];
      sticky = |s2_q.prod[21:0];
      e_n    = s2_q.exp;
    end
    rnd    = guard & (sticky | frac[0]);
    mant_r = {2'b01, frac} + {24'b0, rnd};
    // Carry-out leaves the fraction field all zeros, so only the exponent moves.
    if (mant_r[24]) e_n = e_n + 10'sd1;

    unique case (s2_q.kind)
      K_NAN:   s3_d = 32'h7FC0_0000;
      K_INF:   s3_d = {s2_q.sign, 8'hFF, 23'b0};
      K_ZERO:  s3_d = {s2_q.sign, 31'b0};
      default: begin
        if (e_n >= 10'sd255)    s3_d = {s2_q.sign, 8'hFF, 23'b0};
        else if (e_n <= 10'sd0) s3_d = {s2_q.sign, 31'b0};
        else                    s3_d = {s2_q.sign, e_n[7:0], mant_r[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      out_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.valid_in};
      if (bus.valid_in) begin
        a_q <= bus.in0;
        b_q <= bus.in1;
      end
      if (vld_pipe[0]) s1_q  <= s1_d;
      if (vld_pipe[1]) s2_q  <= s2_d;
      if (vld_pipe[2]) s3_q  <= s3_d;
      if (vld_pipe[3]) out_q <= s3_q;
    end
  end

  assign bus.valid_out = vld_pipe[STAGES];
  assign bus.out0      = out_q;
endmodule

// File: tb/tb_mult_top.sv
// Scoreboard bench for mult_top: driver queues hand-computed products with a
// due cycle, a monitor checks value, timing and absence of stray outputs.
module tb_mult_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_top_if bus();
  mult_top dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample 1 time unit after each rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset) begin
      checks++;
      if (bus.valid_out !== 1'b0 || bus.out0 !== 32'h0) begin
        errors++;
        $display("FAIL rst_state valid_out=%b out0=%h want 0/00000000", bus.valid_out, bus.out0);
      end
    end else if (bus.valid_out === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out out0=%h cyc=%0d", bus.out0, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.out0 !== e.exp || cyc != e.due) begin
          errors++;
          $display("FAIL %s got=%h want=%h at_cyc=%0d due_cyc=%0d", e.name, bus.out0, e.exp, cyc, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL %s missing want=%h due_cyc=%0d", e.name, e.exp, e.due);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input string nm);
    bus.valid_in = 1'b1;
    bus.in0      = a;
    bus.in1      = b;
    sb.push_back('{e, cyc + 5, nm});
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.in0      = '0;
    bus.in1      = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.in0      = '0;
    bus.in1      = '0;
    // Garbage offered during reset must be ignored.
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.in0      = 32'h3F80_0000;
    bus.in1      = 32'h3F80_0000;
    idle(2);
    bus.valid_in = 1'b0;
    reset = 1'b1;

    issue(32'hC000_0000, 32'h418C_0000, 32'hC20C_0000, "single");
    idle(6);

    issue(32'hC000_0000, 32'h418C_0000, 32'hC20C_0000, "b2b_0");
    issue(32'hC049_0FDB, 32'h402D_F854, 32'hC108_A2C0, "b2b_pi_e");
    idle(2);

    issue(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, "inf_x_zero");
    issue(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, "neg_inf");
    idle(1);
    issue(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, "neg_zero");
    issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
    issue(32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, "inf_x_inf");
    issue(32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000, "ninf_x_nzero");
    idle(3);

    issue(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, "overflow");
    issue(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, "underflow");
    issue(32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, "denorm_ftz");

    issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "rnd_1p5sq");
    issue(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, "rnd_sticky");
    issue(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, "tie_up_odd");
    issue(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, "tie_keep_even");
    issue(32'h3FFF_FFFE, 32'h3F80_0001, 32'h4000_0000, "rnd_carry");
    idle(8);

    // Reset mid-stream: none of these three may ever appear.
    issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, "flushed_0");
    issue(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, "flushed_1");
    issue(32'h4080_0000, 32'h4000_0000, 32'h4100_0000, "flushed_2");
    idle(1);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    issue(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, "post_reset");
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_top.md
# mult_top

Pipelined IEEE-754 single-precision (binary32) floating-point multiplier with a valid-qualified streaming interface. Accepts one operand pair per clock, produces the rounded product a fixed 4 cycles later, and has no back-pressure. Sits as a leaf datapath block behind any producer that drives a valid strobe with its operands.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- valid_in  input  1  in0/in1 hold a valid operand pair this cycle.
- valid_out  output  1  out0 holds a valid product this cycle; single-cycle strobe per result.
- in0  input  32  operand A, binary32.
- in1  input  32  operand B, binary32.
- out0  output  32  product A×B, binary32.

## Operation
- Sign = sign(A) XOR sign(B) for all results, including zero and infinity. NaN results always use the canonical pattern 0x7FC00000.
- Special cases are evaluated in this priority order:
  - A or B is NaN -> 0x7FC00000.
  - Infinity × zero -> 0x7FC00000.
  - Infinity × (nonzero finite or infinity) -> signed infinity (exp 0xFF, mantissa 0).
  - Either operand zero -> signed zero.
- Denormal inputs (exp 0, mantissa ≠ 0) are treated as signed zero (flush-to-zero).
- Normal path:
  - 24×24 unsigned multiply of the mantissas with hidden 1 restored, giving a 48-bit product.
  - Exponent = eA + eB − 127, computed in at least 10-bit signed arithmetic.
  - If product bit 47 is set, shift right 1 and increment the exponent.
  - Round to nearest, ties to even, using guard and sticky (OR of all lower bits).
  - If mantissa rounding carries out, renormalize and increment the exponent again.
- Result exponent ≥ 255 -> signed infinity (overflow).
- Result exponent ≤ 0 -> signed zero (underflow flush; no denormal outputs).
- Inexact, overflow and underflow flags are not reported.

## Timing
- Fully pipelined, 4 register stages:
  - S1: unpack, classify operands, XOR signs.
  - S2: mantissa multiply, exponent add.
  - S3: normalize, round, apply special-case override.
  - S4: output register.
- Latency: a pair sampled with valid_in=1 at rising edge k appears on out0, with valid_out=1, immediately after edge k+4.
- Throughput: one pair per cycle. Back-to-back valid_in cycles give back-to-back valid_out cycles in the same order.
- Gaps in valid_in are preserved exactly at the output; there is no handshake or stall.
- When valid_out=0, out0 is don't-care; the implementation holds 0 or the last value.
- Reset (reset=0 at a rising edge):
  - All valid pipeline bits clear, so valid_out=0 and out0=0 from the following cycle.
  - In-flight operations are discarded and never emerge.
  - Inputs are ignored while reset is asserted.
  - The first pair accepted is the one sampled at the first edge with reset=1.
- Data registers may be enable-gated by their stage valid bit to save power. This gating is not observable at the interface.

## Test plan
- Reset, then apply in0=0xC0000000 (−2) and in1=0x418C0000 (17.5) for one cycle -> exactly 4 cycles later valid_out=1 and out0=0xC20C0000 (−35), for one cycle only.
- Back-to-back pairs: (0xC0000000, 0x418C0000) then (0xC0490FDB −π, 0x402DF854 e) -> consecutive outputs 0xC20C0000 then 0xC108A2C0.
- Specials:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000.
  - 0xFF800000 × 0x40000000 -> 0xFF800000.
  - 0x80000000 × 0x3F800000 -> 0x80000000.
  - 0x7FC00001 × 0x3F800000 -> 0x7FC00000.
- Overflow/underflow:
  - 0x7F000000 × 0x40000000 -> 0x7F800000.
  - 0x00800000 × 0x3F000000 -> 0x00000000.
  - Denormal 0x00000001 × 0x3F800000 -> 0x00000000.
- Rounding: 0x3FC00000 × 0x3FC00000 -> 0x40100000. Then 0x3F800001 × 0x3F800001 -> 0x3F800002, checking the sticky bit and tie handling.
- Reset mid-stream: issue 3 valid pairs, assert reset for 1 cycle 2 cycles after the last pair -> no valid_out for any of the 3 pairs; a new pair after reset release returns its product 4 cycles later.
